// File: rtl/lsu_mem_initiator_if.sv
// Bundle of core request/response and memory-port signals for lsu_mem_initiator.
//
// Signals:
//   req_valid/req_ready       core request handshake
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                 request fields (store data right-aligned)
//   resp_valid, resp_rdata,
//   resp_err                  one-cycle completion pulse with load data / error flag
//   mem_read_en/write_en,
//   mem_address,
//   mem_write_data,
//   mem_read_data             word-wide memory port (combinational read)
//
// Modports:
//   slave  - the initiator itself (receives requests, drives the memory port)
//   master - the surrounding core plus memory (issues requests, serves the memory port)
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_read_en, mem_write_en, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_read_en, mem_write_en, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Core-side load/store initiator for one word-wide memory port.
//
// Accepts byte/halfword/word loads and stores, aligns and sign/zero-extends load data,
// and turns sub-word stores into a read-modify-write because the memory only writes
// whole words.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   lsu_io  lsu_mem_initiator_if.slave: request/response handshake and memory port
//
// Parameters:
//   PAGE_BYTES  page size in bytes, only used by the optional bounds check
//
// Build option:
//   LSU_BOUNDS_CHECK_EN  when defined, addresses >= PAGE_BYTES complete with an error
//                        and no memory access; otherwise upper address bits pass through
//                        and alias within the page in the memory decoder.
module lsu_mem_initiator #(
  parameter int unsigned PAGE_BYTES = 4096
) (
  input logic                  clk,
  input logic                  rst,
  lsu_mem_initiator_if.slave   lsu_io
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BoundsCheck = 1'b1;
`else
  localparam bit BoundsCheck = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        out_of_range;
  logic        req_err;
  logic        is_word_q;
  logic [4:0]  lane_shamt;
  logic [31:0] lane_word;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged_word;

  // Request decode, evaluated on the live request fields at the accept edge.
  always_comb begin
    accept       = lsu_io.req_valid && (state_q == StIdle);
    out_of_range = BoundsCheck && (lsu_io.req_addr >= PAGE_BYTES);
    req_err      = (lsu_io.req_size == 2'b11)
                || ((lsu_io.req_size == 2'b01) && lsu_io.req_addr[0])
                || ((lsu_io.req_size == 2'b10) && (lsu_io.req_addr[1:0] != 2'b00))
                || out_of_range;
  end

  // Lane extraction and merge, working on the latched request and live read data.
  always_comb begin
    is_word_q  = (size_q == 2'b10);
    lane_shamt = {addr_q[1:0], 3'b000};
    lane_word  = lsu_io.mem_read_data >> lane_shamt;
    half_lane  = addr_q[1] ? lsu_io.mem_read_data[31:16] : lsu_io.mem_read_data[15:0];

    load_val = lsu_io.mem_read_data;
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'h000000, lane_word[7:0]}
                                : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_val = uns_q ? {16'h0000, half_lane}
                                : {{16{half_lane[15]}}, half_lane};
      default: load_val = lsu_io.mem_read_data;
    endcase

    // Halfword addresses are even, so the byte shift also positions the halfword.
    lane_mask   = (size_q == 2'b00) ? (32'h0000_00ff << lane_shamt)
                                    : (32'h0000_ffff << lane_shamt);
    merged_word = (lsu_io.mem_read_data & ~lane_mask) | ((wdata_q << lane_shamt) & lane_mask);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = lsu_io.req_we;
          size_d  = lsu_io.req_size;
          uns_d   = lsu_io.req_unsigned;
          addr_d  = lsu_io.req_addr;
          wdata_d = lsu_io.req_wdata;
          if (req_err) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = load_val;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (is_word_q) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          merged_d = merged_word;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // All outputs come from registered state only, so reset kills them asynchronously.
  logic        req_ready;
  logic        resp_valid;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_data;

  always_comb begin
    req_ready      = (state_q == StIdle);
    resp_valid     = (state_q == StResp);
    mem_read_en    = (state_q == StAccess) && !(we_q && is_word_q);
    mem_write_en   = ((state_q == StAccess) && we_q && is_word_q) || (state_q == StWrite);
    mem_write_data = 32'h0;
    if (state_q == StWrite) begin
      mem_write_data = merged_q;
    end else if ((state_q == StAccess) && we_q && is_word_q) begin
      mem_write_data = wdata_q;
    end
  end

  assign lsu_io.req_ready      = req_ready;
  assign lsu_io.resp_valid     = resp_valid;
  assign lsu_io.resp_rdata     = rdata_q;
  assign lsu_io.resp_err       = err_q;
  assign lsu_io.mem_read_en    = mem_read_en;
  assign lsu_io.mem_write_en   = mem_write_en;
  assign lsu_io.mem_address    = {addr_q[31:2], 2'b00};
  assign lsu_io.mem_write_data = mem_write_data;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: directed cases plus random traffic checked
// against a word-array reference model; a monitor compares responses and memory writes.
module tb_lsu_mem_initiator;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;

  exp_t exp_q[$];
  wr_t  exp_wr[$];

  logic [31:0] mem   [1024];
  logic [31:0] model [1024];

  lsu_mem_initiator_if bus ();

  lsu_mem_initiator #(
    .PAGE_BYTES(4096)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .lsu_io (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory port: combinational read, write on the rising edge, decodes bits [11:2].
  assign bus.mem_read_data = mem[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (bus.mem_write_en) begin
      mem[bus.mem_address[11:2]] <= bus.mem_write_data;
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: responses and memory writes checked against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_read_en) rd_cnt++;
      if (bus.mem_write_en) wr_cnt++;
      if (bus.mem_read_en || bus.mem_write_en) begin
        check("rd_wr_exclusive", {31'h0, bus.mem_read_en & bus.mem_write_en}, 32'h0);
      end
      if (bus.mem_write_en) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'h1, 32'h0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_address", bus.mem_address, w.addr);
          check("write_data", bus.mem_write_data, w.data);
        end
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
          check("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Reference model: whole-word memory with byte-lane arithmetic.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output exp_t e, output bit has_wr, output wr_t w);
    logic [31:0] word, mask, val;
    int unsigned sh;
    int unsigned idx;
    bit err;
    idx = int'(addr[11:2]);
    sh  = 8 * int'(addr[1:0]);
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
       || (Bounds && addr >= 32'd4096);
    has_wr  = 1'b0;
    w       = '0;
    e       = '0;
    e.err   = err;
    e.rdata = 32'h0;
    e.lat   = err ? 0 : ((we && size != 2'd2) ? 2 : 1);
    if (!err) begin
      word = model[idx];
      if (!we) begin
        if (size == 2'd0) begin
          val = (word >> sh) & 32'hFF;
          if (!uns && val[7]) val = val | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
          val = (word >> sh) & 32'hFFFF;
          if (!uns && val[15]) val = val | 32'hFFFF_0000;
        end else begin
          val = word;
        end
        e.rdata = val;
      end else begin
        mask = (size == 2'd0) ? (32'hFF << sh) : (size == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        val  = (word & ~mask) | ((wdata << sh) & mask);
        model[idx] = val;
        has_wr = 1'b1;
        w.addr = addr & 32'hFFFF_FFFC;
        w.data = val;
      end
    end
  endtask

  // Called and returning at a negedge; holds the request until accepted.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int unsigned acc);
    int n;
    exp_t e;
    bit has_wr;
    wr_t w;
    n = 0;
    acc = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'h0, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    model_req(we, size, uns, addr, wdata, e, has_wr, w);
    acc   = cyc + 1;
    e.acc = acc;
    exp_q.push_back(e);
    if (has_wr) exp_wr.push_back(w);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after accept; the block must have latched them.
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_wr.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() + exp_wr.size(), 32'h0);
    @(negedge clk);
  endtask

  int unsigned a1, a2, r0, w0;
  logic [31:0] old_word;

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (2) @(negedge clk);
    check("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("reset_resp_rdata", bus.resp_rdata, 32'h0);
    check("reset_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("reset_mem_read_en", {31'h0, bus.mem_read_en}, 32'h0);
    check("reset_mem_write_en", {31'h0, bus.mem_write_en}, 32'h0);
    check("reset_mem_address", bus.mem_address, 32'h0);
    check("reset_mem_write_data", bus.mem_write_data, 32'h0);
    mem_clr = 1'b0;
    rst     = 1'b0;
    @(negedge clk);

    // Word store then load, back to back.
    do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF, a1);
    do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, a2);
    check("sw_to_lw_accept_spacing", a2 - a1, 32'd3);

    // Byte and halfword loads with extension.
    do_req(1'b1, 2'd2, 1'b0, 32'h020, 32'h80FF_7F01, a1);
    do_req(1'b0, 2'd0, 1'b0, 32'h023, 32'h0, a1);
    do_req(1'b0, 2'd0, 1'b1, 32'h023, 32'h0, a1);
    do_req(1'b0, 2'd0, 1'b0, 32'h020, 32'h0, a1);
    do_req(1'b0, 2'd1, 1'b0, 32'h022, 32'h0, a1);
    do_req(1'b0, 2'd1, 1'b1, 32'h022, 32'h0, a1);

    // Sub-word read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'h030, 32'h1122_3344, a1);
    do_req(1'b1, 2'd0, 1'b0, 32'h031, 32'hFFFF_FFAA, a1);
    do_req(1'b1, 2'd1, 1'b0, 32'h032, 32'h1234_BEEF, a1);
    do_req(1'b0, 2'd2, 1'b0, 32'h030, 32'h0, a1);
    drain();
    check("rmw_result_in_memory", mem[12], 32'hBEEF_AA44);

    // Misaligned and illegal requests never touch memory.
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, a1);
    do_req(1'b0, 2'd1, 1'b0, 32'h005, 32'h0, a1);
    do_req(1'b0, 2'd3, 1'b0, 32'h008, 32'h0, a1);
    do_req(1'b1, 2'd2, 1'b0, 32'h00E, 32'h1, a1);
    drain();
    check("error_no_reads", rd_cnt - r0, 32'h0);
    check("error_no_writes", wr_cnt - w0, 32'h0);

    // Upper-page addresses: error with bounds checking, aliasing without.
    w0 = wr_cnt;
    if (Bounds) begin
      do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h5, a1);
      drain();
      check("bounds_no_write", wr_cnt - w0, 32'h0);
    end else begin
      do_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'h5, a1);
      do_req(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, a1);
      drain();
      check("alias_write_count", wr_cnt - w0, 32'h1);
    end

    // Reset during the write cycle of a byte store.
    old_word = model[12];
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h030;
    bus.req_wdata    = 32'h55;
    exp_wr.push_back('{addr: 32'h030, data: (old_word & 32'hFFFF_FF00) | 32'h55});
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rmw_write_cycle_reached", {31'h0, bus.mem_write_en}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("reset_drops_write_en", {31'h0, bus.mem_write_en}, 32'h0);
    check("reset_no_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    exp_wr.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("aborted_write_mem_unchanged", mem[12], old_word);
    check("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
    repeat (4) @(negedge clk);

    // Random traffic over a small window so loads hit earlier stores.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, a1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Core-side load/store initiator that drives one per-core port of the four-page main memory (word-indexed, combinational read, write on rising clock edge). It accepts byte/halfword/word load and store requests from the core's MEM stage and aligns load data with sign or zero extension. Because the memory port only writes whole words, it performs sub-word stores as a read-modify-write. One instance sits between each core and its memory port.

## Interface
- PAGE_BYTES, 4096, size of the core's page in bytes; used by the bounds check only.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads: zero-extend (lbu/lhu) instead of sign-extend.
- req_addr  input  32  byte address within the page.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  output  1  misaligned/illegal/out-of-range; valid with resp_valid.
- mem_read_en  output  1  to memory port read enable.
- mem_write_en  output  1  to memory port write enable.
- mem_address  output  32  {latched addr[31:2], 2'b00}.
- mem_write_data  output  32  word to write.
- mem_read_data  input  32  combinational read data from memory port.

## Operation
- Handshake: request accepted at a rising edge where req_valid && req_ready; fields latched into internal registers; core may change inputs afterwards.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On accept: if error -> RESP with resp_err=1, no memory access; else -> ACCESS.
- Error: size 11; halfword with addr[0]=1; word with addr[1:0]!=00; out-of-range address when bounds checking is compiled in (see Configuration).
- ACCESS, load: mem_read_en=1; at the edge, select lane from mem_read_data and register into resp_rdata. Byte lane = addr[1:0]; half lane = addr[1]. Extend from bit 7/15 unless req_unsigned. -> RESP.
- ACCESS, word store: mem_write_en=1, mem_write_data=req_wdata; the memory writes at the edge. -> RESP.
- ACCESS, sub-word store: mem_read_en=1; at the edge, register the merged word: mem_read_data with the addressed byte replaced by wdata[7:0], or the addressed half replaced by wdata[15:0]. -> WRITE.
- WRITE: mem_write_en=1, mem_write_data=merged word, mem_read_en=0. -> RESP.
- RESP: resp_valid=1 for exactly one cycle. -> IDLE.
- Memory-side outputs are decoded from registered state only; outside a read or write cycle they are 0. mem_address holds the latched word address.
- Read and write enables are never high in the same cycle.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_write_data=0; state=IDLE.
- Accept at edge E0. Load or word store: access cycle E0..E1, resp_valid in cycle E1..E2. Sub-word store: read E0..E1, write E1..E2, resp_valid E2..E3. Error: resp_valid E0..E1.
- Throughput: one load or word store per 3 cycles; one sub-word store per 4; back-to-back accept is allowed in the cycle after RESP.
- req_valid while not IDLE is ignored; the core holds the request until req_ready.
- Reset mid-operation: outputs drop immediately (async). A write whose edge has not occurred is not performed; no resp_valid is produced for the aborted request.
- resp_rdata/resp_err hold their value until the next response.

## Configuration
- LSU_BOUNDS_CHECK_EN defined: req_addr >= PAGE_BYTES is an error: no memory access, resp_err=1.
- Undefined: no range check; upper address bits pass through and the memory decodes only bits [11:2], so addresses alias within the page.

## Test plan
- Word store then load: sw 0xDEADBEEF @0x010, then lw @0x010 -> one write cycle with mem_address=0x010; load resp_rdata=0xDEADBEEF, resp_err=0, 3 cycles accept-to-accept.
- Byte loads: word 0x80FF7F01 @0x020; lb @0x023 -> 0xFFFFFF80; lbu @0x023 -> 0x00000080; lb @0x020 -> 0x00000001; lh @0x022 -> 0xFFFF80FF.
- Sub-word RMW: word 0x11223344 @0x030; sb 0xAA @0x031 -> read cycle then write cycle with mem_write_data=0x1122AA44; sh 0xBEEF @0x032 -> 0xBEEFAA44; resp_valid 3 cycles after accept.
- Misalignment: lw @0x002, lh @0x005, size=11 -> resp_err=1 one cycle after accept; mem_read_en and mem_write_en never asserted.
- Bounds: with LSU_BOUNDS_CHECK_EN, sw @0x1000 -> resp_err=1, no write. Without it, sw 0x5 @0x1004 writes the word that lw @0x004 returns.
- Reset mid-RMW: assert rst during the WRITE state before the edge -> mem_write_en drops immediately, memory word unchanged, resp_valid never pulses, req_ready=1 after release.
